fpu_issue_arbiter: RTL and testbench

//  Shares one FP ALU (add op=0 / mul op=1, 1-cycle registered latency, output muxed by the

---
 rtl/fpu_pkg.sv | 14 +
 rtl/fpu_rsp_fifo.sv | 53 +++++
 rtl/fpu_issue_arbiter.sv | 135 +++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP issue definitions: opcodes, canonical NaN and arbiter state encoding.
package fpu_pkg;

  localparam logic        OP_ADD = 1'b0;
  localparam logic        OP_MUL = 1'b1;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StSwitch
  } arb_state_e;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO; head data reads as zero while empty.
module fpu_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   valid_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0]       mem_q [Depth];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [$clog2(Depth):0] cnt_q, cnt_d;
  logic                   pop_ok;

  assign pop_ok  = pop_i & (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_i && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue of requester FP ops onto one shared ALU with in-order tagged responses.
module fpu_issue_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_vld_i,
  output logic [NUM_REQ-1:0]         req_rdy_o,
  input  logic [NUM_REQ*32-1:0]      req_a_i,
  input  logic [NUM_REQ*32-1:0]      req_b_i,
  input  logic [NUM_REQ-1:0]         req_op_i,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag_i,
  output logic                       alu_vld_o,
  output logic [31:0]                alu_a_o,
  output logic [31:0]                alu_b_o,
  output logic                       alu_op_o,
  input  logic [31:0]                alu_res_i,
  input  logic                       alu_res_vld_i,
  input  logic                       alu_ovf_i,
  output logic                       rsp_vld_o,
  input  logic                       rsp_rdy_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [TAG_W-1:0]           rsp_tag_o,
  output logic [31:0]                rsp_res_o,
  output logic                       rsp_ovf_o
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned EntW = IdW + TAG_W + 33;

  arb_state_e             state_q, state_d;
  logic [IdW-1:0]         ptr_q, ptr_d, cand, id_q;
  logic [TAG_W-1:0]       tag_q;
  logic [31:0]            alu_a_q, alu_b_q;
  logic                   alu_op_q;
  logic                   err_q;
  logic                   found, credit_ok, op_ok, grant, inflight, push, pop;
  logic [$clog2(RSP_DEPTH):0] fifo_cnt;
  logic [EntW-1:0]        fifo_rdata;

  // The ALU is busy exactly in the cycle after a grant.
  assign inflight = (state_q == StBusy);

  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_vld_i[(32'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        cand  = IdW'((32'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // The in-flight result lands in the FIFO this cycle, so it already consumes a slot.
  assign credit_ok = (32'(fifo_cnt) + 32'(inflight)) < RSP_DEPTH;
  // The ALU output mux follows alu_op, which must stay put while a result is captured.
  assign op_ok     = !inflight || (req_op_i[cand] == alu_op_q);
  assign grant     = !rst && found && credit_ok && op_ok && (state_q != StSwitch);

  always_comb begin
    req_rdy_o = '0;
    if (grant) req_rdy_o[cand] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant) ptr_d = (cand == IdW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    unique case (state_q)
      StIdle:   if (grant) state_d = StBusy;
      StBusy: begin
        if (grant)               state_d = StBusy;
        else if (found && !op_ok) state_d = StSwitch;
        else                     state_d = StIdle;
      end
      StSwitch: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      id_q     <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        alu_a_q  <= req_a_i[32*cand +: 32];
        alu_b_q  <= req_b_i[32*cand +: 32];
        alu_op_q <= req_op_i[cand];
        id_q     <= cand;
        tag_q    <= req_tag_i[TAG_W*cand +: TAG_W];
      end
      // Sticky: ALU failed to return a result in its slot.
      err_q <= err_q | (inflight & ~alu_res_vld_i);
    end
  end

  assign alu_vld_o = inflight;
  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign alu_op_o  = alu_op_q;

  assign push = inflight && alu_res_vld_i;
  assign pop  = rsp_vld_o && rsp_rdy_i;

  fpu_rsp_fifo #(
    .Width (EntW),
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({id_q, tag_q, alu_res_i, alu_ovf_i}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (rsp_vld_o),
    .count_o (fifo_cnt)
  );

  assign {rsp_id_o, rsp_tag_o, rsp_res_o, rsp_ovf_o} = fifo_rdata;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Randomized and directed checks of fpu_issue_arbiter against a transaction-level model.
module tb_fpu_issue_arbiter;
  import fpu_pkg::*;

  localparam int unsigned NReq  = 4;
  localparam int unsigned TagW  = 4;
  localparam int unsigned Depth = 4;
  localparam int unsigned IdW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NReq-1:0]      req_vld, req_rdy, req_op;
  logic [NReq*32-1:0]   req_a, req_b;
  logic [NReq*TagW-1:0] req_tag;
  logic                 alu_vld, alu_op, alu_res_vld, alu_ovf;
  logic [31:0]          alu_a, alu_b, alu_res;
  logic                 rsp_vld, rsp_rdy, rsp_ovf;
  logic [IdW-1:0]       rsp_id;
  logic [TagW-1:0]      rsp_tag;
  logic [31:0]          rsp_res;

  fpu_issue_arbiter #(
    .NUM_REQ   (NReq),
    .TAG_W     (TagW),
    .RSP_DEPTH (Depth)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_vld_i     (req_vld),
    .req_rdy_o     (req_rdy),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .req_op_i      (req_op),
    .req_tag_i     (req_tag),
    .alu_vld_o     (alu_vld),
    .alu_a_o       (alu_a),
    .alu_b_o       (alu_b),
    .alu_op_o      (alu_op),
    .alu_res_i     (alu_res),
    .alu_res_vld_i (alu_res_vld),
    .alu_ovf_i     (alu_ovf),
    .rsp_vld_o     (rsp_vld),
    .rsp_rdy_i     (rsp_rdy),
    .rsp_id_o      (rsp_id),
    .rsp_tag_o     (rsp_tag),
    .rsp_res_o     (rsp_res),
    .rsp_ovf_o     (rsp_ovf)
  );

  // Small-integer float helpers: operands stay exact so results are known precisely.
  function automatic logic [31:0] i2f(input int unsigned v);
    int p;
    p = 0;
    if (v == 0) return 32'h0;
    for (int k = 0; k < 32; k++) if (v[k]) p = k;
    return {1'b0, 8'(127 + p), 23'(v << (23 - p))};
  endfunction

  function automatic int unsigned f2v(input logic [31:0] f, output bit ok);
    int e;
    int unsigned m;
    ok = 1'b0;
    e  = int'(f[30:23]) - 127;
    if (f[31] || e < 0 || e > 23) return 0;
    m = {8'h0, 1'b1, f[22:0]};
    if ((m & ((32'd1 << (23 - e)) - 1)) != 0) return 0;
    ok = 1'b1;
    return m >> (23 - e);
  endfunction

  function automatic logic [32:0] alu_model(input logic [31:0] a, b, input logic op);
    bit oka, okb;
    int unsigned va, vb;
    va = f2v(a, oka);
    vb = f2v(b, okb);
    if (oka && okb) return {1'b0, (op == OP_MUL) ? i2f(va * vb) : i2f(va + vb)};
    if (op == OP_MUL && (int'(a[30:23]) + int'(b[30:23]) - 127) >= 255) return {1'b1, 32'h7F80_0000};
    return {1'b0, QNAN};
  endfunction

  // Stand-in ALU: result valid during the issue cycle, selected by the live opcode.
  always_comb begin
    {alu_ovf, alu_res} = alu_model(alu_a, alu_b, alu_op);
  end
  assign alu_res_vld = alu_vld;

  typedef struct packed {
    logic [IdW-1:0]  id;
    logic [TagW-1:0] tag;
    logic [31:0]     res;
    logic            ovf;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] got_q[$];
  int unsigned m_ptr;
  bit          m_inflight;
  logic        m_op;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [NReq-1:0] s_rdy, s_acc;
  logic            s_alu_vld, s_alu_op, s_rsp_vld, s_rsp_ovf;
  logic [31:0]     s_alu_a, s_alu_b, s_rsp_res;
  logic [IdW-1:0]  s_rsp_id;
  logic [TagW-1:0] s_rsp_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int   qsz, fifo_n, g, want;
    rsp_t e;
    s_rdy = req_rdy;  s_acc = req_rdy & req_vld;
    s_alu_vld = alu_vld;  s_alu_op = alu_op;  s_alu_a = alu_a;  s_alu_b = alu_b;
    s_rsp_vld = rsp_vld;  s_rsp_res = rsp_res;  s_rsp_id = rsp_id;
    s_rsp_tag = rsp_tag;  s_rsp_ovf = rsp_ovf;
    if (rst) begin
      exp_q.delete();
      m_ptr = 0;  m_inflight = 1'b0;  m_op = OP_ADD;
      return;
    end
    qsz    = exp_q.size();
    fifo_n = qsz - int'(m_inflight);
    check("rdy_onehot0", 64'($countones(req_rdy) <= 1), 1);
    check("rdy_without_vld", 64'((req_rdy & ~req_vld) == '0), 1);
    check("alu_vld", alu_vld, m_inflight);
    if (m_inflight) check("alu_op_hold", alu_op, m_op);
    check("rsp_vld", rsp_vld, fifo_n > 0);
    if (rsp_vld && fifo_n > 0) begin
      e = exp_q[0];
      check("rsp_id", rsp_id, e.id);
      check("rsp_tag", rsp_tag, e.tag);
      check("rsp_res", rsp_res, e.res);
      check("rsp_ovf", rsp_ovf, e.ovf);
      if (rsp_rdy) begin
        exp_q.delete(0);
        got_q.push_back(rsp_res);
      end
    end
    if (s_acc != '0) begin
      g = 0;
      for (int i = 0; i < NReq; i++) if (s_acc[i]) g = i;
      want = -1;
      for (int k = 0; k < NReq; k++)
        if (want < 0 && req_vld[(m_ptr + k) % NReq]) want = int'((m_ptr + k) % NReq);
      check("rr_pick", g, want);
      check("credit", 64'(qsz < Depth), 1);
      if (m_inflight) check("op_switch_blocked", req_op[g], m_op);
      e.id  = IdW'(g);
      e.tag = req_tag[TagW*g +: TagW];
      {e.ovf, e.res} = alu_model(req_a[32*g +: 32], req_b[32*g +: 32], req_op[g]);
      exp_q.push_back(e);
      m_ptr      = (g + 1) % NReq;
      m_inflight = 1'b1;
      m_op       = req_op[g];
    end else begin
      m_inflight = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [TagW-1:0] tag);
    req_vld[i]           = v;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
    req_op[i]            = op;
    req_tag[TagW*i +: TagW] = tag;
  endtask

  task automatic rnd_req(input int i, input logic op);
    set_req(i, 1'b1, i2f($urandom_range(1, 64)), i2f($urandom_range(1, 64)), op,
            TagW'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NReq; i++) rnd_req(i, OP_ADD);
    cyc();
    check("rst_req_rdy", s_rdy, 0);
    check("rst_alu_vld", s_alu_vld, 0);
    check("rst_alu_a", s_alu_a, 0);
    check("rst_alu_op", s_alu_op, 0);
    check("rst_rsp_vld", s_rsp_vld, 0);
    check("rst_rsp_data", {s_rsp_id, s_rsp_tag, s_rsp_res, s_rsp_ovf}, 0);
    req_vld = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_vld = '0;
    rsp_rdy = 1'b1;
    for (int k = 0; k < n; k++) cyc();
    check("drain_empty", exp_q.size(), 0);
  endtask

  int  n_acc;
  bit  seen;

  initial begin
    req_vld = '0;  req_a = '0;  req_b = '0;  req_op = '0;  req_tag = '0;  rsp_rdy = 1'b0;
    do_reset();

    // Single add: grant, issue one cycle later, response two cycles after grant.
    rsp_rdy = 1'b1;
    set_req(0, 1'b1, 32'h3F80_0000, 32'h4000_0000, OP_ADD, 4'd5);
    cyc();
    check("t1_grant", s_acc, 4'b0001);
    req_vld = '0;
    cyc();
    check("t1_alu_vld", s_alu_vld, 1);
    check("t1_alu_ab", {s_alu_a, s_alu_b}, {32'h3F80_0000, 32'h4000_0000});
    check("t1_rsp_early", s_rsp_vld, 0);
    cyc();
    check("t1_rsp_vld", s_rsp_vld, 1);
    check("t1_rsp", {s_rsp_res, 30'(s_rsp_id), s_rsp_tag, s_rsp_ovf},
          {32'h4040_0000, 30'd0, 4'd5, 1'b0});
    drain(4);

    // All requesters busy with adds: back-to-back rotation.
    do_reset();
    rsp_rdy = 1'b1;
    for (int i = 0; i < NReq; i++) rnd_req(i, OP_ADD);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t2_rotation", s_acc, 4'b0001 << (k % NReq));
      for (int i = 0; i < NReq; i++) if (s_acc[i]) rnd_req(i, OP_ADD);
    end
    drain(8);

    // Add followed by mul: the mul waits out the switch, both results intact.
    do_reset();
    rsp_rdy = 1'b1;
    got_q.delete();
    set_req(0, 1'b1, 32'h4000_0000, 32'h4040_0000, OP_ADD, 4'd1);
    set_req(1, 1'b1, 32'h4000_0000, 32'h4040_0000, OP_MUL, 4'd2);
    cyc();
    check("t3_add_grant", s_acc, 4'b0001);
    req_vld[0] = 1'b0;
    cyc();
    check("t3_bubble", s_acc, 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!seen) begin
        cyc();
        seen = s_acc[1];
      end
    end
    check("t3_mul_grant", seen, 1);
    drain(6);
    check("t3_rsp_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("t3_add_res", got_q[0], 32'h40A0_0000);
      check("t3_mul_res", got_q[1], 32'h40C0_0000);
    end

    // Stalled response port: exactly Depth ops accepted, then all delivered in order.
    do_reset();
    rsp_rdy = 1'b0;
    n_acc = 0;
    for (int i = 0; i < NReq; i++) rnd_req(i, OP_ADD);
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (s_acc != '0) n_acc++;
      for (int i = 0; i < NReq; i++) if (s_acc[i]) rnd_req(i, OP_ADD);
    end
    check("t4_accepts", n_acc, Depth);
    check("t4_stalled", s_rdy, 0);
    got_q.delete();
    drain(12);
    check("t4_delivered", got_q.size(), Depth);

    // Multiply overflow to infinity.
    do_reset();
    rsp_rdy = 1'b1;
    set_req(2, 1'b1, 32'h7F00_0000, 32'h7F00_0000, OP_MUL, 4'd9);
    cyc();
    check("t5_grant", s_acc, 4'b0100);
    req_vld = '0;
    cyc();
    cyc();
    check("t5_rsp", {s_rsp_vld, s_rsp_res, s_rsp_ovf, 30'(s_rsp_id), s_rsp_tag},
          {1'b1, 32'h7F80_0000, 1'b1, 30'd2, 4'd9});
    drain(4);

    // Reset with one op in flight and two results queued.
    do_reset();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) rnd_req(i, OP_ADD);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t6_fill", s_acc, 4'b0001 << k);
      req_vld = req_vld & ~s_acc;
    end
    rst = 1'b1;
    #1;
    check("t6_rdy", req_rdy, 0);
    check("t6_alu", {alu_vld, alu_op, alu_a, alu_b}, 0);
    check("t6_rsp", {rsp_vld, rsp_id, rsp_tag, rsp_res, rsp_ovf}, 0);
    req_vld = '0;
    cyc();
    cyc();
    rst = 1'b0;
    rsp_rdy = 1'b1;
    got_q.delete();
    for (int k = 0; k < 6; k++) cyc();
    check("t6_no_rsp", got_q.size(), 0);
    for (int i = 0; i < NReq; i++) rnd_req(i, OP_ADD);
    cyc();
    check("t6_ptr_zero", s_acc, 4'b0001);
    drain(8);

    // Random traffic with mixed opcodes and back-pressure.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rsp_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NReq; i++) begin
        if (!req_vld[i] || s_acc[i]) begin
          if ($urandom_range(0, 99) < 55) rnd_req(i, 1'($urandom_range(0, 1)));
          else req_vld[i] = 1'b0;
        end
      end
      cyc();
    end
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
